ctrl_fsm: RTL and testbench

- Multi-cycle RV32I control unit that sequences FETCH -> DECODE -> EXEC -> MEM -> WB per instruction.
- Replaces the purely combinational decoder with a registered state machine and adds the following:
  - full branch set (beq/bne/blt/bge/bltu/bgeu), lui/auipc, and subword load/store sizes;
  - req/ack handshakes to instruction and data memory, with a bounded wait timeout;
  - a sticky trap on illegal opcode or bus timeout.
- Sits between the instruction register/PC and the datapath (regfile, ALU, branch comparator, LSU).

---
 rtl/ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_decode.sv | 66 ++++++
 rtl/ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Optional performance counters are enabled with CTRL_PERF_CNT_EN.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_ALU_R,
        CL_ALU_I,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE
    } cls_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_REG    = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] OPA_RS1  = 2'd0;
    localparam logic [1:0] OPA_PC   = 2'd1;
    localparam logic [1:0] OPA_ZERO = 2'd2;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] alu_op;
        logic [2:0] funct3;
    } dec_t;

    function automatic logic [3:0] alu_from_f3(logic [2:0] f3, logic alt);
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classification of an RV32I instruction word.
// Produces instruction class, ALU op, funct3 and an illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        illegal_o
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic       f7_ok;
    logic       alt;
    logic       unused_bits;

    assign opc   = instr_i[6:2];
    assign f3    = instr_i[14:12];
    assign alt   = instr_i[30];
    assign f7_ok = (instr_i[31:25] == 7'b0000000) ||
                   (instr_i[31:25] == 7'b0100000);
    assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        dec_o        = '0;
        dec_o.funct3 = f3;
        dec_o.alu_op = ALU_ADD;
        illegal_o    = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            unique case (opc)
                OPC_REG: begin
                    dec_o.cls    = CL_ALU_R;
                    dec_o.alu_op = alu_from_f3(f3, alt);
                    illegal_o    = !f7_ok;
                end
                OPC_IMM: begin
                    // bit 30 is part of the immediate except for shifts
                    dec_o.cls    = CL_ALU_I;
                    dec_o.alu_op = alu_from_f3(f3, alt & (f3 == 3'b101));
                    illegal_o    = (f3[1:0] == 2'b01) && !f7_ok;
                end
                OPC_LUI:   dec_o.cls = CL_LUI;
                OPC_AUIPC: dec_o.cls = CL_AUIPC;
                OPC_JAL:   dec_o.cls = CL_JAL;
                OPC_JALR:  dec_o.cls = CL_JALR;
                OPC_BRANCH: begin
                    dec_o.cls = CL_BRANCH;
                    illegal_o = (f3[2:1] == 2'b01);
                end
                OPC_LOAD: begin
                    dec_o.cls = CL_LOAD;
                    illegal_o = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                end
                OPC_STORE: begin
                    dec_o.cls = CL_STORE;
                    illegal_o = f3[2] || (f3[1:0] == 2'b11);
                end
                OPC_FENCE, OPC_SYSTEM: dec_o.cls = CL_NOP;
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky trap.
// Define CTRL_PERF_CNT_EN to add cycle and retired-instruction counters.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CNT_W    = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         instr_i,
    input  logic                imem_ack_i,
    input  logic                dmem_ack_i,
    input  logic                br_less_i,
    input  logic                br_equal_i,
    output logic                imem_req_o,
    output logic                ir_wren_o,
    output logic                pc_wren_o,
    output logic                br_sel_o,
    output logic                br_unsigned_o,
    output logic [1:0]          op_a_sel_o,
    output logic                op_b_sel_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                rd_wren_o,
    output logic                mem_rden_o,
    output logic                mem_wren_o,
    output logic [2:0]          lsu_size_o,
    output logic [1:0]          wb_sel_o,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]         cycle_cnt_o,
    output logic [31:0]         instret_cnt_o,
`endif
    output logic                trap_o,
    output logic [1:0]          trap_cause_o
);

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q;
    logic [31:0]         ir_q;
    dec_t                dec, dec_q;
    logic                illegal;
    logic [1:0]          cause_q, cause_d;
    logic                waiting;
    logic                limit;
    logic                taken;

    ctrl_decode u_decode (
        .instr_i   (ir_q),
        .dec_o     (dec),
        .illegal_o (illegal)
    );

    assign waiting = ((state_q == FETCH) && !imem_ack_i) ||
                     ((state_q == MEM) && !dmem_ack_i);
    assign limit   = (MEM_TIMEOUT != 0) &&
                     (cnt_q == TO_CNT_W'(MEM_TIMEOUT - 1));
    assign taken   = (dec_q.funct3[2] ? br_less_i : br_equal_i) ^
                     dec_q.funct3[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            ir_q    <= '0;
            dec_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            if (state_d != state_q) cnt_q <= '0;
            else if (waiting)       cnt_q <= cnt_q + 1'b1;
            if ((state_q == FETCH) && imem_ack_i) ir_q <= instr_i;
            if (state_q == DECODE) dec_q <= dec;
            if ((state_d == TRAP) && (state_q != TRAP)) cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        unique case (state_q)
            FETCH: begin
                if (imem_ack_i) begin
                    state_d = DECODE;
                end else if (limit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            DECODE: begin
                if (illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (dec_q.cls)
                    CL_BRANCH:          state_d = FETCH;
                    CL_LOAD, CL_STORE:  state_d = MEM;
                    default:            state_d = WB;
                endcase
            end
            MEM: begin
                if (dmem_ack_i) begin
                    state_d = (dec_q.cls == CL_LOAD) ? WB : FETCH;
                end else if (limit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req_o    = 1'b0;
        ir_wren_o     = 1'b0;
        pc_wren_o     = 1'b0;
        br_sel_o      = 1'b0;
        br_unsigned_o = 1'b0;
        op_a_sel_o    = OPA_RS1;
        op_b_sel_o    = 1'b0;
        alu_op_o      = '0;
        rd_wren_o     = 1'b0;
        mem_rden_o    = 1'b0;
        mem_wren_o    = 1'b0;
        lsu_size_o    = '0;
        wb_sel_o      = WB_ALU;
        // operand selects stay put from EXEC through WB so the ALU result holds
        if (state_q inside {EXEC, MEM, WB}) begin
            alu_op_o = ALU_OP_W'(dec_q.alu_op);
            unique case (dec_q.cls)
                CL_ALU_I, CL_JALR, CL_LOAD, CL_STORE: begin
                    op_b_sel_o = 1'b1;
                end
                CL_LUI: begin
                    op_a_sel_o = OPA_ZERO;
                    op_b_sel_o = 1'b1;
                end
                CL_AUIPC, CL_JAL, CL_BRANCH: begin
                    op_a_sel_o = OPA_PC;
                    op_b_sel_o = 1'b1;
                end
                default: ;
            endcase
        end
        unique case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                ir_wren_o  = imem_ack_i;
            end
            EXEC: begin
                if (dec_q.cls == CL_BRANCH) begin
                    br_unsigned_o = dec_q.funct3[1];
                    br_sel_o      = taken;
                    pc_wren_o     = 1'b1;
                end
            end
            MEM: begin
                mem_rden_o = (dec_q.cls == CL_LOAD);
                mem_wren_o = (dec_q.cls == CL_STORE);
                lsu_size_o = dec_q.funct3;
                pc_wren_o  = (dec_q.cls == CL_STORE) && dmem_ack_i;
            end
            WB: begin
                rd_wren_o = (dec_q.cls != CL_NOP);
                pc_wren_o = 1'b1;
                if (dec_q.cls inside {CL_JAL, CL_JALR}) begin
                    br_sel_o = 1'b1;
                    wb_sel_o = WB_PC4;
                end else if (dec_q.cls == CL_LOAD) begin
                    wb_sel_o = WB_LOAD;
                end
            end
            default: ;
        endcase
    end

    assign trap_o       = (state_q == TRAP);
    assign trap_cause_o = cause_q;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
        end else begin
            if (state_q != TRAP) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (pc_wren_o) instret_cnt_o <= instret_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed testbench for ctrl_fsm: vector table plus hand-written
// sequences for waits, timeouts, illegal decode and mid-instruction reset.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        br_less = 1'b0;
    logic        br_equal = 1'b0;
    logic        imem_req_o, ir_wren_o, pc_wren_o, br_sel_o, br_unsigned_o;
    logic [1:0]  op_a_sel_o;
    logic        op_b_sel_o;
    logic [3:0]  alu_op_o;
    logic        rd_wren_o, mem_rden_o, mem_wren_o;
    logic [2:0]  lsu_size_o;
    logic [1:0]  wb_sel_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_fsm #(.ALU_OP_W(4), .MEM_TIMEOUT(16), .TO_CNT_W(5)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_i       (instr),
        .imem_ack_i    (imem_ack),
        .dmem_ack_i    (dmem_ack),
        .br_less_i     (br_less),
        .br_equal_i    (br_equal),
        .imem_req_o    (imem_req_o),
        .ir_wren_o     (ir_wren_o),
        .pc_wren_o     (pc_wren_o),
        .br_sel_o      (br_sel_o),
        .br_unsigned_o (br_unsigned_o),
        .op_a_sel_o    (op_a_sel_o),
        .op_b_sel_o    (op_b_sel_o),
        .alu_op_o      (alu_op_o),
        .rd_wren_o     (rd_wren_o),
        .mem_rden_o    (mem_rden_o),
        .mem_wren_o    (mem_wren_o),
        .lsu_size_o    (lsu_size_o),
        .wb_sel_o      (wb_sel_o),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o),
`endif
        .trap_o        (trap_o),
        .trap_cause_o  (trap_cause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        less;
        logic        eq;
        int          alu;
        int          a;
        int          b;
        int          bru;
        int          brsel;
        int          pcw;
        int          wb;
        int          rdw;
        int          wbsel;
        int          wbbr;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        br_less  = 1'b0;
        br_equal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // one FETCH cycle with immediate ack; returns in DECODE
    task automatic fetch(input logic [31:0] w);
        instr    = w;
        imem_ack = 1'b1;
        smp();
        chk("fetch req", 32'(imem_req_o), 32'd1);
        chk("fetch ir_wren", 32'(ir_wren_o), 32'd1);
        chk("fetch wren", 32'({pc_wren_o, rd_wren_o}), 32'd0);
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        fetch(v.instr);
        smp();
        chk($sformatf("v%0d dec idle", i),
            32'({imem_req_o, rd_wren_o, pc_wren_o, mem_rden_o, mem_wren_o}),
            32'd0);
        cyc();
        br_less  = v.less;
        br_equal = v.eq;
        smp();
        chk($sformatf("v%0d alu", i), 32'(alu_op_o), 32'(v.alu));
        chk($sformatf("v%0d op_a", i), 32'(op_a_sel_o), 32'(v.a));
        chk($sformatf("v%0d op_b", i), 32'(op_b_sel_o), 32'(v.b));
        chk($sformatf("v%0d br_uns", i), 32'(br_unsigned_o), 32'(v.bru));
        chk($sformatf("v%0d br_sel", i), 32'(br_sel_o), 32'(v.brsel));
        chk($sformatf("v%0d ex pcw", i), 32'(pc_wren_o), 32'(v.pcw));
        chk($sformatf("v%0d ex rdw", i), 32'(rd_wren_o), 32'd0);
        cyc();
        if (v.wb != 0) begin
            smp();
            chk($sformatf("v%0d wb rdw", i), 32'(rd_wren_o), 32'(v.rdw));
            chk($sformatf("v%0d wb pcw", i), 32'(pc_wren_o), 32'd1);
            chk($sformatf("v%0d wb_sel", i), 32'(wb_sel_o), 32'(v.wbsel));
            chk($sformatf("v%0d wb br", i), 32'(br_sel_o), 32'(v.wbbr));
            cyc();
        end
        smp();
        chk($sformatf("v%0d back fetch", i),
            32'({imem_req_o, trap_o}), 32'b10);
        cyc();
    endtask

    task automatic illegal_case(input logic [31:0] w, input string nm);
        do_reset();
        fetch(w);
        smp();
        chk({nm, " dec no trap"}, 32'(trap_o), 32'd0);
        cyc();
        smp();
        chk({nm, " trap"}, 32'({trap_o, trap_cause_o}), 32'b101);
        chk({nm, " no wren"}, 32'({rd_wren_o, pc_wren_o}), 32'd0);
        imem_ack = 1'b1;
        cyc();
        smp();
        chk({nm, " sticky"}, 32'({trap_o, imem_req_o, pc_wren_o}), 32'b100);
        cyc();
        imem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h002081B3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{32'h402081B3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[2]  = '{32'h4020D1B3, 0, 0, 9, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{32'h0020B1B3, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[4]  = '{32'h00500093, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[5]  = '{32'h0FF0F093, 0, 0, 6, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{32'h123452B7, 0, 0, 0, 2, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[7]  = '{32'h00001297, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[8]  = '{32'h008000EF, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 2, 1};
        vecs[9]  = '{32'h000100E7, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 1};
        vecs[10] = '{32'h00208463, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{32'h00209463, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[12] = '{32'h0020D463, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[13] = '{32'h0020D463, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{32'h0020E463, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        vecs[15] = '{32'h0020F463, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[16] = '{32'h0000000F, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[17] = '{32'h00000073, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

        do_reset();
        smp();
        chk("reset req", 32'(imem_req_o), 32'd1);
        chk("reset outs",
            32'({ir_wren_o, pc_wren_o, br_sel_o, br_unsigned_o, op_a_sel_o,
                 op_b_sel_o, alu_op_o, rd_wren_o, mem_rden_o, mem_wren_o,
                 lsu_size_o, wb_sel_o, trap_o, trap_cause_o}), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        chk("reset perf", {cycle_cnt_o | instret_cnt_o}, 32'd0);
`endif
        cyc();

        for (int i = 0; i < 18; i++) run_vec(i);
`ifdef CTRL_PERF_CNT_EN
        chk("instret", instret_cnt_o, 32'd18);
`endif

        // lh with ack delayed three cycles
        fetch(32'h00011083);
        cyc();
        smp();
        chk("lh exec", 32'({op_a_sel_o, op_b_sel_o, mem_rden_o}), 32'b0010);
        cyc();
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("lh wait%0d", k),
                32'({mem_rden_o, lsu_size_o, pc_wren_o}), 32'b10010);
            cyc();
        end
        dmem_ack = 1'b1;
        smp();
        chk("lh ack", 32'({mem_rden_o, lsu_size_o, pc_wren_o}), 32'b10010);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("lh wb", 32'({rd_wren_o, pc_wren_o, wb_sel_o, mem_rden_o}),
            32'b11010);
        cyc();
        smp();
        chk("lh fetch", 32'(imem_req_o), 32'd1);
        cyc();

        // sb with immediate ack retires from MEM
        fetch(32'h00208023);
        cyc();
        cyc();
        dmem_ack = 1'b1;
        smp();
        chk("sb mem", 32'({mem_wren_o, pc_wren_o, br_sel_o, lsu_size_o}),
            32'b110000);
        cyc();
        dmem_ack = 1'b0;
        smp();
        chk("sb fetch", 32'({imem_req_o, mem_wren_o, rd_wren_o}), 32'b100);
        cyc();

        // sw never acked: 16 MEM cycles, then sticky trap cause 3
        fetch(32'h0020A023);
        cyc();
        cyc();
        for (int k = 1; k <= 16; k++) begin
            smp();
            if (k == 1 || k == 16)
                chk($sformatf("sw mem%0d", k),
                    32'({mem_wren_o, lsu_size_o, trap_o}), 32'b10100);
            cyc();
        end
        smp();
        chk("sw trap", 32'({trap_o, trap_cause_o}), 32'b111);
        chk("sw trap idle", 32'({mem_wren_o, imem_req_o, pc_wren_o}), 32'd0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (3) cyc();
        smp();
        chk("sw sticky", 32'({trap_o, trap_cause_o, pc_wren_o}), 32'b1110);
        cyc();
        do_reset();
        smp();
        chk("trap cleared", 32'({imem_req_o, trap_o, trap_cause_o}), 32'b1000);
        cyc();

        // ack on the 16th FETCH cycle beats the timeout
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            smp();
            if (k == 15) chk("fetch wait15", 32'({imem_req_o, trap_o}), 32'b10);
            cyc();
        end
        fetch(32'h0000000F);
        smp();
        chk("late ack decode", 32'({imem_req_o, trap_o}), 32'b00);
        cyc();
        cyc();
        smp();
        chk("late ack wb", 32'({pc_wren_o, rd_wren_o}), 32'b10);
        cyc();

        // no ack at all: FETCH timeout trap
        do_reset();
        for (int k = 0; k < 16; k++) cyc();
        smp();
        chk("fetch timeout", 32'({trap_o, trap_cause_o, imem_req_o}), 32'b1100);
        cyc();

        illegal_case(32'hFFFFFFFF, "ill ffff");
        illegal_case(32'h0020A463, "ill br010");
        illegal_case(32'h00013083, "ill ld011");
        illegal_case(32'h0020B023, "ill st011");
        illegal_case(32'h802081B3, "ill f7");

        // reset asserted mid-MEM aborts the store
        do_reset();
        fetch(32'h0020A023);
        cyc();
        cyc();
        smp();
        chk("mem before rst", 32'(mem_wren_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst abort", 32'({imem_req_o, mem_wren_o, pc_wren_o}), 32'b100);
`ifdef CTRL_PERF_CNT_EN
        chk("rst perf", {cycle_cnt_o | instret_cnt_o}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        smp();
        chk("post rst", 32'({imem_req_o, trap_o}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
